fifo_reader: RTL and testbench
==============================

# fifo_reader

Read-side burst engine for the team's synchronous FIFO. On a `start` command it pulls `burst_len` words out of an upstream FIFO through that FIFO's `read`/`empty`/`data_out` port and presents each word on a valid/ready stream interface toward the downstream consumer. It pulses `done` once the whole burst has been handed off. It sits between the FIFO and any block that consumes data at its own pace.

## Interface
- `WIDTH`, 8: data word width.
- `LEN_W`, 4: width of `burst_len` and `count`; maximum burst is 2^LEN_W−1 words.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  burst request; sampled only in IDLE.
- `burst_len`  in  LEN_W  words in burst; latched when `start` is accepted.
- `abort`  in  1  synchronous burst cancel.
- `busy`  out  1  high while a burst is in progress (all states except IDLE).
- `done`  out  1  one-cycle pulse at burst completion.
- `count`  out  LEN_W  words delivered in current/last burst.
- `fifo_rd`  out  1  read strobe to the FIFO (combinational: `state==REQ && !fifo_empty`).
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  WIDTH  FIFO read data; valid the cycle after `fifo_rd`.
- `m_data`  out  WIDTH  stream data, registered.
- `m_valid`  out  1  stream valid, registered.
- `m_ready`  in  1  stream ready from the consumer.

## Operation
- FSM states: IDLE, REQ, CAPT, PRESENT, DONE.
- IDLE: `start && burst_len!=0` → latch `remaining=burst_len`, clear `count`, go to REQ. `start` with `burst_len==0` is ignored. `start` in any other state is ignored.
- REQ: `fifo_rd=1` whenever `!fifo_empty`, then go to CAPT. While `fifo_empty` is high, stay in REQ with `fifo_rd=0`. The block never reads an empty FIFO, so no underflow can occur.
- CAPT: `fifo_data` is valid. At the clock edge, `m_data<=fifo_data`, `m_valid<=1`, go to PRESENT.
- PRESENT: hold `m_data`/`m_valid` stable until `m_ready`. On `m_valid&&m_ready`:
  - `count+=1`, `remaining-=1`, `m_valid<=0`.
  - Go to DONE if `remaining==1`; otherwise go to REQ.
- DONE: `done=1` and `busy=1` for exactly one cycle, then go to IDLE.
- `abort` in REQ/CAPT/PRESENT/DONE: go to IDLE next edge with `m_valid<=0`.
  - No `done` pulse.
  - A word already read from the FIFO (CAPT/PRESENT) is discarded, not re-inserted.
  - `count` keeps the number of words actually handed off.
  - `abort` in IDLE has no effect. When `abort` and `m_ready` are high in the same PRESENT cycle, `abort` wins: no handshake and no `count` increment.
- `count` holds its value after DONE/abort until the next accepted `start`. It never wraps, because `count` ≤ `burst_len`.

## Timing
- Reset (`reset`=0, asynchronous) values: state IDLE, `m_data=0`, `m_valid=0`, `done=0`, `busy=0`, `count=0`, `remaining=0`, `fifo_rd=0`. Outputs change immediately, without waiting for `clk`.
- Reset deassertion takes effect at the next rising edge.
- Reset mid-burst discards the burst. The FIFO keeps any words not yet read.
- The edge that accepts `start` moves the FSM to REQ in cycle 1.
- Cycle counts with a non-empty FIFO and `m_ready` held high:
  - `fifo_rd` is high in cycle 1, CAPT is cycle 2, and `m_valid` is high in cycle 3.
  - Each word takes 3 cycles, so word k shows `m_valid` in cycle 3k.
  - `done` is high in cycle 3N+1 and IDLE is reached in cycle 3N+2.
- `fifo_rd` is high for at most one cycle per word and only in REQ.
- `m_data` never changes while `m_valid=1` and `m_ready=0`.

## Test plan
- **Async reset:** during PRESENT of a burst, drive `reset`=0 between clock edges. Required: `m_valid`, `busy`, `done`, `count` and `m_data` read 0 before the next edge. After release, `start` with `burst_len=2` runs normally.
- **Nominal burst:** FIFO holds 0xA1, 0xB2, 0xC3; `burst_len=3`; `m_ready=1`. Required: `m_data` = 0xA1 / 0xB2 / 0xC3 with `m_valid` in cycles 3, 6 and 9; `done` in cycle 10; `count=3`; exactly 3 `fifo_rd` pulses; `busy` low from cycle 11.
- **Empty stall:** `burst_len=2` with `fifo_empty=1` for 5 cycles, then a write of 0x5A. Required: `fifo_rd=0` and `busy=1` throughout the stall. `fifo_rd` pulses in the first cycle `fifo_empty=0`, and 0x5A appears 2 cycles later.
- **Backpressure:** `m_ready=0` for 4 cycles while 0x3C is presented. Required: `m_data=0x3C` and `m_valid=1` stable for all 4 cycles, no `fifo_rd`, `count` unchanged. The handshake happens on the first `m_ready=1` cycle.
- **Ignored starts:** `start` with `burst_len=0` in IDLE produces no state change and no `fifo_rd`. `start` with `burst_len=5` during a 2-word burst still yields `count=2` and a single `done`.
- **Abort:** assert `abort` in CAPT of word 2 of a 4-word burst. Required: IDLE next cycle, `m_valid=0`, no `done`, `count=1`. The FIFO has lost exactly 2 words.

Source files
------------

// File: rtl/fifo_reader.sv
// -----------------------------------------------------------------------------
// fifo_reader
//
// Read-side burst engine for the synchronous FIFO. A start command pulls
// burst_len words out of the upstream FIFO and hands each one to a downstream
// consumer over a valid/ready stream. done pulses once the whole burst has
// been handed off. abort cancels a burst in progress.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   reset       asynchronous active-low reset
//   start       burst request, sampled only in IDLE
//   burst_len   words in the burst, latched when start is accepted
//   abort       synchronous burst cancel
//   busy        high in every state except IDLE
//   done        one-cycle pulse at burst completion
//   count       words delivered in the current / last burst
//   fifo_rd     FIFO read strobe (combinational)
//   fifo_empty  FIFO empty flag
//   fifo_data   FIFO read data, valid the cycle after fifo_rd
//   m_data      stream data (registered)
//   m_valid     stream valid (registered)
//   m_ready     stream ready from the consumer
//
// States
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | waiting for start with a non-zero burst_len
//   S_REQ     | strobe fifo_rd as soon as the FIFO is not empty
//   S_CAPT    | fifo_data valid; capture it into m_data, raise m_valid
//   S_PRESENT | hold m_data/m_valid until the consumer accepts the word
//   S_DONE    | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module fifo_reader #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] count,
    output logic             fifo_rd,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_CAPT    = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = '0;
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    state_t           state;
    state_t           state_next;
    logic [LEN_W-1:0] remaining;

    logic start_ok;
    logic handshake;

    assign start_ok  = start && (burst_len != LEN_ZERO);
    // abort takes priority over a same-cycle m_ready: the word is dropped
    assign handshake = (state == S_PRESENT) && m_valid && m_ready && !abort;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (!fifo_empty) begin
                    state_next = S_CAPT;
                end
            end
            S_CAPT: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    state_next = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (handshake) begin
                    // remaining still holds the pre-decrement value here
                    if (remaining == LEN_ONE) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_REQ;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        fifo_rd = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_REQ: begin
                busy = 1'b1;
                // The strobe depends only on the FIFO flag; an abort in this
                // cycle still consumes the word being read.
                fifo_rd = !fifo_empty;
            end
            S_CAPT, S_PRESENT: begin
                busy = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: burst bookkeeping and registered stream outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            count     <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        remaining <= burst_len;
                        count     <= '0;
                    end
                end
                S_CAPT: begin
                    if (!abort) begin
                        m_data  <= fifo_data;
                        m_valid <= 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (abort) begin
                        m_valid <= 1'b0;
                    end else if (handshake) begin
                        count     <= count + LEN_ONE;
                        remaining <= remaining - LEN_ONE;
                        m_valid   <= 1'b0;
                    end
                end
                default: begin
                    if (abort) begin
                        m_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
module tb_fifo_reader;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] burst_len;
    logic       abort;
    logic       busy;
    logic       done;
    logic [3:0] count;
    logic       fifo_rd;
    logic       fifo_empty;
    logic [7:0] fifo_data = 8'h00;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    int checks = 0;
    int errors = 0;

    // FIFO model: words written by the stimulus, read one per fifo_rd,
    // read data appears the cycle after the strobe.
    logic [7:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] ref_q [$];
    bit         sb_en = 1'b0;

    int rd_pulses   = 0;
    int done_pulses = 0;
    int hs_count    = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    assign fifo_empty = (wr_ptr == rd_ptr);

    fifo_reader #(.WIDTH(8), .LEN_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .burst_len  (burst_len),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .fifo_rd    (fifo_rd),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr] = v;
        ref_q.push_back(v);
        wr_ptr++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Protocol monitor: counts strobes/pulses/handshakes, checks stream
    // stability under backpressure and the scoreboard in the random phase.
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (fifo_rd) rd_pulses <= rd_pulses + 1;
            if (done) done_pulses <= done_pulses + 1;
            check("rd_while_empty", 32'(fifo_rd && fifo_empty), 32'd0);
            if (prev_stall) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && m_ready && !abort) begin
                hs_count <= hs_count + 1;
                if (sb_en) begin
                    if (ref_q.size() == 0) begin
                        checks++;
                        errors++;
                        $error("FAIL sb_data: observed 0x%0h expected none (no word outstanding)", m_data);
                    end else begin
                        check("sb_data", 32'(m_data), 32'(ref_q.pop_front()));
                    end
                end
            end
            prev_stall <= m_valid && !m_ready && !abort;
            prev_data  <= m_data;
        end
    end

    // Runs an n-word burst with m_ready high and a non-empty FIFO, checking
    // the cycle-exact timeline. late: keep a start(len 5) asserted mid-burst.
    task automatic run_burst(input int n, input logic [7:0] w [4], input bit late, input string tag);
        int rd0;
        int dn0;
        int c;
        rd0 = rd_pulses;
        dn0 = done_pulses;
        start = 1'b1;
        burst_len = 4'(n);
        for (c = 1; c <= 3*n + 2; c++) begin
            cyc();
            if (!late || c >= 3*n - 1) start = 1'b0;
            else burst_len = 4'd5;
            settle();
            check($sformatf("%s_rd_c%0d", tag, c), 32'(fifo_rd), 32'(c % 3 == 1 && c <= 3*n - 2));
            check($sformatf("%s_valid_c%0d", tag, c), 32'(m_valid), 32'(c % 3 == 0 && c <= 3*n));
            if (c % 3 == 0 && c <= 3*n)
                check($sformatf("%s_data_c%0d", tag, c), 32'(m_data), 32'(w[c/3 - 1]));
            check($sformatf("%s_done_c%0d", tag, c), 32'(done), 32'(c == 3*n + 1));
            check($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(c <= 3*n + 1));
            check($sformatf("%s_count_c%0d", tag, c), 32'(count), 32'(((c - 1) / 3 < n) ? (c - 1) / 3 : n));
        end
        check({tag, "_rd_total"}, 32'(rd_pulses - rd0), 32'(n));
        check({tag, "_done_total"}, 32'(done_pulses - dn0), 32'd1);
    endtask

    initial begin
        logic [7:0] w [4];
        int rd0;
        int dn0;
        int hs0;
        int ll;
        int pushed;
        int pre;
        bit got_done;

        reset = 1'b0;
        start = 1'b0;
        burst_len = 4'd0;
        abort = 1'b0;
        m_ready = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_rd", 32'(fifo_rd), 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        cyc();
        cyc();

        // Nominal 3-word burst
        push(8'hA1); push(8'hB2); push(8'hC3);
        w[0] = 8'hA1; w[1] = 8'hB2; w[2] = 8'hC3; w[3] = 8'h00;
        run_burst(3, w, 1'b0, "nom");

        // Empty stall followed by backpressure on the second word
        start = 1'b1;
        burst_len = 4'd2;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            start = 1'b0;
            settle();
            check($sformatf("stall_rd_c%0d", c), 32'(fifo_rd), 32'd0);
            check($sformatf("stall_busy_c%0d", c), 32'(busy), 32'd1);
        end
        cyc();
        push(8'h5A);
        settle();
        check("stall_rd_release", 32'(fifo_rd), 32'd1);
        cyc(); settle();
        check("stall_capt_valid", 32'(m_valid), 32'd0);
        cyc(); settle();
        check("stall_word_valid", 32'(m_valid), 32'd1);
        check("stall_word_data", 32'(m_data), 32'h5A);
        cyc();
        m_ready = 1'b0;
        push(8'h3C);
        settle();
        check("bp_req_rd", 32'(fifo_rd), 32'd1);
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc();
            settle();
            check($sformatf("bp_valid_%0d", i), 32'(m_valid), 32'd1);
            check($sformatf("bp_data_%0d", i), 32'(m_data), 32'h3C);
            check($sformatf("bp_rd_%0d", i), 32'(fifo_rd), 32'd0);
            check($sformatf("bp_count_%0d", i), 32'(count), 32'd1);
        end
        m_ready = 1'b1;
        cyc(); settle();
        check("bp_done", 32'(done), 32'd1);
        check("bp_count_final", 32'(count), 32'd2);
        cyc(); settle();
        check("bp_idle", 32'(busy), 32'd0);

        // Ignored starts
        rd0 = rd_pulses;
        start = 1'b1;
        burst_len = 4'd0;
        cyc(); settle();
        check("zero_len_busy", 32'(busy), 32'd0);
        check("zero_len_rd", 32'(fifo_rd), 32'd0);
        check("zero_len_count", 32'(count), 32'd2);
        start = 1'b0;
        cyc(); settle();
        check("zero_len_busy2", 32'(busy), 32'd0);
        check("zero_len_rd_total", 32'(rd_pulses - rd0), 32'd0);
        push(8'h11); push(8'h22);
        w[0] = 8'h11; w[1] = 8'h22;
        run_burst(2, w, 1'b1, "late");
        cyc(); settle();
        check("late_stays_idle", 32'(busy), 32'd0);

        // Abort in CAPT of word 2 of a 4-word burst
        push(8'h41); push(8'h42); push(8'h43); push(8'h44);
        rd0 = rd_pulses;
        dn0 = done_pulses;
        start = 1'b1;
        burst_len = 4'd4;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            start = 1'b0;
        end
        settle();
        check("abort_in_capt", 32'(m_valid), 32'd0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        settle();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(m_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_count", 32'(count), 32'd1);
        cyc(); settle();
        check("abort_no_done", 32'(done_pulses - dn0), 32'd0);
        check("abort_words_lost", 32'(rd_pulses - rd0), 32'd2);
        w[0] = 8'h43; w[1] = 8'h44;
        run_burst(2, w, 1'b0, "post_abort");

        // Asynchronous reset during PRESENT of word 2
        push(8'h61); push(8'h62);
        start = 1'b1;
        burst_len = 4'd2;
        for (int c = 1; c <= 6; c++) begin
            cyc();
            start = 1'b0;
            if (c == 4) m_ready = 1'b0;
        end
        settle();
        check("pre_rst_valid", 32'(m_valid), 32'd1);
        check("pre_rst_count", 32'(count), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_data", 32'(m_data), 32'd0);
        check("arst_rd", 32'(fifo_rd), 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        m_ready = 1'b1;
        cyc();
        push(8'h63); push(8'h64);
        w[0] = 8'h63; w[1] = 8'h64;
        run_burst(2, w, 1'b0, "post_rst");

        // Randomized bursts against the queue scoreboard
        ref_q.delete();
        sb_en = 1'b1;
        for (int b = 0; b < 16; b++) begin
            ll = $urandom_range(1, 15);
            pre = $urandom_range(0, ll);
            pushed = 0;
            for (int i = 0; i < pre; i++) begin
                push(8'($urandom));
                pushed++;
            end
            rd0 = rd_pulses;
            dn0 = done_pulses;
            hs0 = hs_count;
            start = 1'b1;
            burst_len = 4'(ll);
            cyc();
            start = 1'b0;
            got_done = 1'b0;
            for (int k = 0; k < 400 && !got_done; k++) begin
                m_ready = 1'($urandom_range(0, 1));
                if (pushed < ll && $urandom_range(0, 2) == 0) begin
                    push(8'($urandom));
                    pushed++;
                end
                settle();
                if (done) got_done = 1'b1;
                else cyc();
            end
            check($sformatf("rand%0d_done_seen", b), 32'(got_done), 32'd1);
            check($sformatf("rand%0d_count", b), 32'(count), 32'(ll));
            cyc(); settle();
            check($sformatf("rand%0d_idle", b), 32'(busy), 32'd0);
            check($sformatf("rand%0d_rd_total", b), 32'(rd_pulses - rd0), 32'(ll));
            check($sformatf("rand%0d_done_total", b), 32'(done_pulses - dn0), 32'd1);
            check($sformatf("rand%0d_hs_total", b), 32'(hs_count - hs0), 32'(ll));
            // Top up any words the burst did not need so the next one starts clean
            while (pushed < ll) begin
                push(8'($urandom));
                pushed++;
            end
        end
        check("rand_leftover", 32'(ref_q.size()), 32'(wr_ptr - rd_ptr));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
